taxi_qsfp_mgmt_target: RTL and testbench

//  I2C target (responder) emulating a QSFP28 module management interface (SFF-8636 lower page) at 7-bit address DEV_ADDR.

---
 rtl/taxi_qsfp_mgmt_pkg.sv | 29 ++
 rtl/taxi_i2c_line_filter.sv | 56 +++++
 rtl/taxi_qsfp_mgmt_target.sv | 234 +++++++++++++++++++++++
 tb/tb_taxi_qsfp_mgmt_target.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_qsfp_mgmt_pkg.sv
// Shared types and SFF-8636 lower-page offsets for the QSFP management target.
package taxi_qsfp_mgmt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } mgmt_state_t;

    // Filtered bus level and single-cycle bus events.
    typedef struct packed {
        logic sda;
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } line_evt_t;

    localparam logic [7:0] SFF_ID_ADDR  = 8'h00;
    localparam logic [7:0] SFF_IRQ_ADDR = 8'h03;

endpackage

// File: rtl/taxi_i2c_line_filter.sv
// SCL/SDA synchroniser and glitch filter; emits edge and START/STOP pulses.
module taxi_i2c_line_filter
    import taxi_qsfp_mgmt_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      scl_i,
    input  logic      sda_i,
    output line_evt_t evt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    // Bit 1 carries SCL, bit 0 carries SDA.
    logic [1:0]         raw, sync0, sync1, filt, filt_d;
    logic [1:0][CW-1:0] cnt;

    assign raw = {scl_i, sda_i};

    // 2FF sync, then a new level is accepted only after FILTER_LEN stable cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0  <= '1;
            sync1  <= '1;
            filt   <= '1;
            filt_d <= '1;
            cnt    <= '0;
        end else begin
            sync0  <= raw;
            sync1  <= sync0;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync1[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync1[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // START/STOP need SCL high both before and after the SDA edge
    assign evt = '{
        sda:      filt[0],
        scl_rise: filt[1] & ~filt_d[1],
        scl_fall: ~filt[1] & filt_d[1],
        start:    filt[1] & filt_d[1] & filt_d[0] & ~filt[0],
        stop:     filt[1] & filt_d[1] & ~filt_d[0] & filt[0]
    };

endmodule

// File: rtl/taxi_qsfp_mgmt_target.sv
// QSFP28 management I2C target: 256-byte map, auto-increment pointer, latched IRQ byte.
module taxi_qsfp_mgmt_target
    import taxi_qsfp_mgmt_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter logic [7:0] IRQ_ADDR   = SFF_IRQ_ADDR,
    parameter int         FILTER_LEN = 4,
    parameter int         HOLD_CYC   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    input  logic       modsell,
    input  logic       resetl,
    output logic       intl,
    input  logic       loc_wr_en,
    input  logic [7:0] loc_addr,
    input  logic [7:0] loc_wr_data,
    output logic [7:0] loc_rd_data,
    input  logic [7:0] irq_set,
    output logic       busy
);

    localparam int HW = $clog2(HOLD_CYC + 2);

    line_evt_t         evt;
    mgmt_state_t       state, state_d;
    logic [1:0]        resetl_sync;
    logic              resetl_s;
    logic [255:0][7:0] mem;
    logic [7:0]        mem_rd, shift_q, shift_d, ptr_q, ptr_d;
    logic [3:0]        bit_cnt, cnt_d;
    logic [HW-1:0]     hold_cnt;
    logic              sda_pend, sda_t_q;
    logic              pend_ld, pend_val, rel_now, i2c_we, rd_ld, rd_clr;

    taxi_i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .scl_i (scl_i),
        .sda_i (sda_i),
        .evt   (evt)
    );

    assign resetl_s = resetl_sync[1];
    assign mem_rd   = mem[ptr_q];
    assign rd_clr   = rd_ld && (ptr_q == IRQ_ADDR);
    assign busy     = (state != ST_IDLE) && (state != ST_IGNORE);
    assign intl     = ~|mem[IRQ_ADDR];
    assign sda_o    = 1'b0;
    // modsell is ORed in directly so deselect releases the line without waiting a clock
    assign sda_t    = sda_t_q | modsell;

    // Module reset synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) resetl_sync <= 2'b00;
        else        resetl_sync <= {resetl_sync[0], resetl};
    end

    // Next-state and per-event datapath control; global conditions override bus decoding
    always_comb begin
        state_d  = state;
        cnt_d    = bit_cnt;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        pend_ld  = 1'b0;
        pend_val = 1'b1;
        rel_now  = 1'b0;
        i2c_we   = 1'b0;
        rd_ld    = 1'b0;
        if (!resetl_s) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            rel_now = 1'b1;
        end else if (evt.stop) begin
            state_d = ST_IDLE;
            rel_now = 1'b1;
        end else if (evt.start) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            rel_now = 1'b1;
        end else if (modsell && busy) begin
            state_d = ST_IGNORE;
            rel_now = 1'b1;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (evt.scl_rise) begin
                        shift_d = {shift_q[6:0], evt.sda};
                        cnt_d   = bit_cnt + 4'd1;
                    end else if (evt.scl_fall && bit_cnt == 4'd8) begin
                        pend_ld  = 1'b1;
                        pend_val = 1'b0;
                        if (state == ST_ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_IGNORE;
                                pend_ld = 1'b0;
                            end
                        end else if (state == ST_PTR) begin
                            ptr_d   = shift_q;
                            state_d = ST_PTR_ACK;
                        end else begin
                            // The flag byte is read-only from the bus but still ACKed
                            i2c_we  = (ptr_q != IRQ_ADDR);
                            ptr_d   = ptr_q + 8'd1;
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (evt.scl_fall) begin
                        cnt_d = '0;
                        if (shift_q[0]) begin
                            state_d = ST_RDATA;
                            rd_ld   = 1'b1;
                        end else begin
                            state_d = ST_PTR;
                            pend_ld = 1'b1;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (evt.scl_fall) begin
                        state_d = ST_WDATA;
                        cnt_d   = '0;
                        pend_ld = 1'b1;
                    end
                end
                ST_RDATA: begin
                    // bit_cnt==9 marks "initiator ACKed, fetch next byte on this fall"
                    if (evt.scl_rise) begin
                        cnt_d = bit_cnt + 4'd1;
                    end else if (evt.scl_fall) begin
                        if (bit_cnt == 4'd9) begin
                            rd_ld = 1'b1;
                        end else if (bit_cnt == 4'd8) begin
                            state_d = ST_RACK;
                            pend_ld = 1'b1;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            pend_ld  = 1'b1;
                            pend_val = shift_q[6];
                        end
                    end
                end
                ST_RACK: begin
                    if (evt.scl_rise) begin
                        if (evt.sda) begin
                            state_d = ST_IGNORE;
                            rel_now = 1'b1;
                        end else begin
                            state_d = ST_RDATA;
                            cnt_d   = 4'd9;
                        end
                    end
                end
                default: ;
            endcase
            if (rd_ld) begin
                shift_d  = mem_rd;
                ptr_d    = ptr_q + 8'd1;
                cnt_d    = '0;
                pend_ld  = 1'b1;
                pend_val = mem_rd[7];
            end
        end
    end

    // FSM state and bus-side datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shift_q <= '0;
            ptr_q   <= '0;
        end else begin
            state   <= state_d;
            bit_cnt <= cnt_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
        end
    end

    // SDA driver: scheduled changes land HOLD_CYC after the SCL fall, releases are immediate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_t_q  <= 1'b1;
            sda_pend <= 1'b1;
            hold_cnt <= '0;
        end else if (rel_now) begin
            sda_t_q  <= 1'b1;
            hold_cnt <= '0;
        end else if (pend_ld) begin
            sda_pend <= pend_val;
            hold_cnt <= HW'(HOLD_CYC);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HW'(1)) sda_t_q <= sda_pend;
        end
    end

    // Register map: bus port beats local port; flag byte sets win over clear-on-read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < 256; i++) begin
                if (8'(i) == IRQ_ADDR) begin
                    if (!resetl_s)
                        mem[i] <= '0;
                    else
                        mem[i] <= (((loc_wr_en && loc_addr == IRQ_ADDR) ? loc_wr_data : mem[i])
                                   & ~{8{rd_clr}}) | irq_set;
                end else if (i2c_we && ptr_q == 8'(i)) begin
                    mem[i] <= shift_q;
                end else if (loc_wr_en && loc_addr == 8'(i)) begin
                    mem[i] <= loc_wr_data;
                end
            end
        end
    end

    // Local read port, one cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) loc_rd_data <= '0;
        else        loc_rd_data <= mem[loc_addr];
    end

endmodule

// File: tb/tb_taxi_qsfp_mgmt_target.sv
// Directed bench: bit-banged I2C initiator against the QSFP management target.
module tb_taxi_qsfp_mgmt_target;

    localparam int Q = 12;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       modsell = 1'b0;
    logic       resetl = 1'b1;
    logic       loc_wr_en = 1'b0;
    logic [7:0] loc_addr = '0;
    logic [7:0] loc_wr_data = '0;
    logic [7:0] irq_set = '0;
    logic       sda_o, sda_t, intl, busy;
    logic [7:0] loc_rd_data;
    wire        sda_bus = sda_m & (sda_t | sda_o);

    int total = 0;
    int bad = 0;
    int low_cnt = 0;
    logic mon_en = 1'b0;

    taxi_qsfp_mgmt_target dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_i       (scl_m),
        .sda_i       (sda_bus),
        .sda_o       (sda_o),
        .sda_t       (sda_t),
        .modsell     (modsell),
        .resetl      (resetl),
        .intl        (intl),
        .loc_wr_en   (loc_wr_en),
        .loc_addr    (loc_addr),
        .loc_wr_data (loc_wr_data),
        .loc_rd_data (loc_rd_data),
        .irq_set     (irq_set),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mon_en && !sda_t) low_cnt <= low_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b1; cyc(Q);
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        sda_m = b; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        if (glitch) begin
            sda_m = ~b; cyc(1);
            sda_m = b;  cyc(Q - 1);
        end else begin
            cyc(Q);
        end
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i], gmask[i]);
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        ack = ~sda_bus; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; cyc(Q);
            scl_m = 1'b1; cyc(Q);
            d[i] = sda_bus; cyc(Q);
            scl_m = 1'b0; cyc(Q);
        end
        write_bit(~ack, 1'b0);
    endtask

    task automatic loc_wr(input logic [7:0] a, input logic [7:0] d);
        loc_addr = a; loc_wr_data = d; loc_wr_en = 1'b1; cyc(1);
        loc_wr_en = 1'b0;
    endtask

    task automatic loc_rd(input logic [7:0] a, output logic [7:0] d);
        loc_addr = a; cyc(2);
        d = loc_rd_data;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         l0;

        // reset state
        cyc(3);
        chk("rst sda_t", sda_t, 1);
        chk("rst intl", intl, 1);
        chk("rst busy", busy, 0);
        chk("rst loc_rd_data", loc_rd_data, 0);
        rst_n = 1'b1; cyc(4);

        // 1: write two bytes at 10h
        i2c_start;
        write_byte(8'hA0, 8'h00, ack); chk("t1 ack addr", ack, 1);
        chk("t1 busy", busy, 1);
        write_byte(8'h10, 8'h00, ack); chk("t1 ack ptr", ack, 1);
        write_byte(8'h11, 8'h00, ack); chk("t1 ack d0", ack, 1);
        write_byte(8'h22, 8'h00, ack); chk("t1 ack d1", ack, 1);
        i2c_stop; cyc(4);
        chk("t1 busy after stop", busy, 0);
        loc_rd(8'h10, d); chk("t1 mem10", d, 8'h11);
        loc_rd(8'h11, d); chk("t1 mem11", d, 8'h22);

        // 2: random read across the FFh->00h wrap
        loc_wr(8'hFE, 8'hAB); loc_wr(8'hFF, 8'hCD); loc_wr(8'h00, 8'hEF);
        i2c_start;
        write_byte(8'hA0, 8'h00, ack);
        write_byte(8'hFE, 8'h00, ack); chk("t2 ack ptr", ack, 1);
        i2c_start;
        write_byte(8'hA1, 8'h00, ack); chk("t2 ack raddr", ack, 1);
        read_byte(1'b1, d); chk("t2 rd FE", d, 8'hAB);
        read_byte(1'b1, d); chk("t2 rd FF", d, 8'hCD);
        read_byte(1'b0, d); chk("t2 rd 00", d, 8'hEF);
        chk("t2 sda_t after nack", sda_t, 1);
        chk("t2 busy after nack", busy, 0);
        i2c_stop;

        // 3: foreign address 51h
        l0 = low_cnt; mon_en = 1'b1;
        i2c_start;
        write_byte(8'hA2, 8'h00, ack); chk("t3 nack addr", ack, 0);
        chk("t3 busy ignore", busy, 0);
        write_byte(8'h10, 8'h00, ack);
        write_byte(8'h55, 8'h00, ack);
        i2c_stop; mon_en = 1'b0; cyc(2);
        chk("t3 sda never driven", low_cnt - l0, 0);
        loc_rd(8'h10, d); chk("t3 mem10 kept", d, 8'h11);

        // 4: latched flag byte
        chk("t4 intl idle", intl, 1);
        irq_set = 8'h04; cyc(1); irq_set = 8'h00;
        chk("t4 intl after set", intl, 0);
        i2c_start; write_byte(8'hA0, 8'h00, ack); write_byte(8'h03, 8'h00, ack);
        i2c_start; write_byte(8'hA1, 8'h00, ack);
        read_byte(1'b0, d); chk("t4 rd flag", d, 8'h04);
        i2c_stop;
        chk("t4 intl cleared", intl, 1);
        loc_rd(8'h03, d); chk("t4 flag zero", d, 8'h00);
        irq_set = 8'h01; cyc(2);
        i2c_start; write_byte(8'hA0, 8'h00, ack); write_byte(8'h03, 8'h00, ack);
        i2c_start; write_byte(8'hA1, 8'h00, ack);
        read_byte(1'b0, d); chk("t4 rd flag set held", d, 8'h01);
        i2c_stop;
        chk("t4 intl set wins", intl, 0);
        irq_set = 8'h00; cyc(2);
        i2c_start; write_byte(8'hA0, 8'h00, ack); write_byte(8'h03, 8'h00, ack);
        i2c_start; write_byte(8'hA1, 8'h00, ack);
        read_byte(1'b0, d); chk("t4 rd flag latched", d, 8'h01);
        i2c_stop;
        chk("t4 intl final", intl, 1);
        i2c_start; write_byte(8'hA0, 8'h00, ack); write_byte(8'h03, 8'h00, ack);
        write_byte(8'h77, 8'h00, ack); i2c_stop;
        loc_rd(8'h03, d); chk("t4 bus write to flag ignored", d, 8'h00);

        // 5a: modsell deasserted mid-read
        loc_wr(8'h20, 8'h00); loc_wr(8'h21, 8'h5A);
        i2c_start; write_byte(8'hA0, 8'h00, ack); write_byte(8'h20, 8'h00, ack);
        i2c_start; write_byte(8'hA1, 8'h00, ack); chk("t5 ack raddr", ack, 1);
        cyc(Q);
        chk("t5 driving bit", sda_t, 0);
        modsell = 1'b1; cyc(1);
        chk("t5 modsell release", sda_t, 1);
        cyc(2);
        chk("t5 busy ignore", busy, 0);
        modsell = 1'b0;
        i2c_stop;
        i2c_start; write_byte(8'hA1, 8'h00, ack);
        read_byte(1'b0, d); chk("t5 ptr retained", d, 8'h5A);
        i2c_stop;

        // 5b: resetl pulsed mid-write
        loc_wr(8'h30, 8'h3C);
        irq_set = 8'h02; cyc(1); irq_set = 8'h00;
        chk("t5b intl set", intl, 0);
        i2c_start; write_byte(8'hA0, 8'h00, ack); write_byte(8'h30, 8'h00, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b1, 1'b0);
        chk("t5b busy mid write", busy, 1);
        resetl = 1'b0; cyc(6);
        chk("t5b sda_t", sda_t, 1);
        chk("t5b busy", busy, 0);
        chk("t5b intl cleared", intl, 1);
        resetl = 1'b1; cyc(4);
        i2c_stop;
        loc_rd(8'h30, d); chk("t5b mem30 kept", d, 8'h3C);
        i2c_start; write_byte(8'hA1, 8'h00, ack);
        read_byte(1'b0, d); chk("t5b ptr zero", d, 8'hEF);
        i2c_stop;

        // 6: one-cycle SDA glitches while SCL is high
        i2c_start;
        write_byte(8'hA0, 8'h00, ack);
        write_byte(8'h40, 8'h00, ack);
        write_byte(8'hA5, 8'hC0, ack); chk("t6 ack d0", ack, 1);
        write_byte(8'h3C, 8'h81, ack); chk("t6 ack d1", ack, 1);
        i2c_stop;
        loc_rd(8'h40, d); chk("t6 mem40", d, 8'hA5);
        loc_rd(8'h41, d); chk("t6 mem41", d, 8'h3C);

        // 7: write wrap FFh->00h
        i2c_start;
        write_byte(8'hA0, 8'h00, ack); write_byte(8'hFF, 8'h00, ack);
        write_byte(8'h61, 8'h00, ack); write_byte(8'h62, 8'h00, ack);
        i2c_stop;
        loc_rd(8'hFF, d); chk("t7 memFF", d, 8'h61);
        loc_rd(8'h00, d); chk("t7 mem00", d, 8'h62);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
